ir_frame_transmitter: RTL

//  Parametrised successor to the single-frame IR transmitter. Pulse-distance encoder: leader, DATA_WIDTH data bits
//  (LSB first), stop mark and trailer gap, with optional carrier modulation. Also emits a short repeat frame on

---
 rtl/ir_pkg.sv | 26 ++
 rtl/ir_unit_timer.sv | 48 ++++
 rtl/ir_frame_transmitter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ir_pkg.sv
// Shared IR pulse-distance definitions: FSM state encoding and default timing constants
// (in units of T) for the transmitter and future receiver generations.
package ir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LEAD_ON  = 3'd1,
        ST_LEAD_OFF = 3'd2,
        ST_BIT_ON   = 3'd3,
        ST_BIT_OFF  = 3'd4,
        ST_STOP_ON  = 3'd5,
        ST_TRAIL    = 3'd6
    } ir_state_e;

    localparam int unsigned IR_LEADER_ON  = 32'd16;
    localparam int unsigned IR_LEADER_OFF = 32'd8;
    localparam int unsigned IR_REPEAT_OFF = 32'd4;
    localparam int unsigned IR_TRAILER    = 32'd8;
    localparam int unsigned IR_BIT0_SPACE = 32'd1;
    localparam int unsigned IR_BIT1_SPACE = 32'd3;

    function automatic logic is_mark(input ir_state_e s);
        return (s == ST_LEAD_ON) || (s == ST_BIT_ON) || (s == ST_STOP_ON);
    endfunction

endpackage

// File: rtl/ir_unit_timer.sv
// Timing-unit generator: a prescaler dividing the clock into units of T_CLKS cycles and a
// counter of whole units elapsed; both return to zero whenever clear is asserted.
module ir_unit_timer #(
    parameter int unsigned T_CLKS = 32'd16,
    parameter int unsigned UNIT_W = 32'd5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    output logic              unit_tick,
    output logic [UNIT_W-1:0] units_elapsed
);

    localparam int unsigned PRE_W = $clog2(T_CLKS);

    logic [PRE_W-1:0]  pre_q,   pre_d;
    logic [UNIT_W-1:0] units_q, units_d;

    assign unit_tick     = (pre_q == PRE_W'(T_CLKS - 32'd1));
    assign units_elapsed = units_q;

    // Next prescaler / unit count
    always_comb begin
        pre_d   = pre_q;
        units_d = units_q;
        if (clear) begin
            pre_d   = {PRE_W{1'b0}};
            units_d = {UNIT_W{1'b0}};
        end else if (unit_tick) begin
            pre_d   = {PRE_W{1'b0}};
            units_d = units_q + 1'b1;
        end else begin
            pre_d   = pre_q + 1'b1;
        end
    end

    // Counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            pre_q   <= {PRE_W{1'b0}};
            units_q <= {UNIT_W{1'b0}};
        end else begin
            pre_q   <= pre_d;
            units_q <= units_d;
        end
    end

endmodule

// File: rtl/ir_frame_transmitter.sv
// Pulse-distance IR frame transmitter: leader, LSB-first data bits, stop mark and trailer,
// plus a short repeat frame, with optional carrier modulation of marks.
module ir_frame_transmitter
    import ir_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32'd32,
    parameter int unsigned T_CLKS      = 32'd16,
    parameter int unsigned CARRIER_DIV = 32'd4,
    parameter bit          MODULATE    = 1'b1,
    parameter int unsigned LEADER_ON   = IR_LEADER_ON,
    parameter int unsigned LEADER_OFF  = IR_LEADER_OFF,
    parameter int unsigned REPEAT_OFF  = IR_REPEAT_OFF,
    parameter int unsigned TRAILER     = IR_TRAILER
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_start,
    input  logic                  tx_repeat,
    output logic                  tx_port,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int unsigned UNIT_W = $clog2(LEADER_ON + LEADER_OFF + REPEAT_OFF + TRAILER + IR_BIT1_SPACE + 32'd1);
    localparam int unsigned BIT_W  = (DATA_WIDTH > 32'd1) ? $clog2(DATA_WIDTH) : 32'd1;
    localparam int unsigned PH_W   = $clog2(CARRIER_DIV);

    ir_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]      bit_idx_q, bit_idx_d;
    logic                  is_repeat_q, is_repeat_d;
    logic [PH_W-1:0]       phase_q, phase_d;
    logic                  tx_port_q, tx_port_d;
    logic                  tx_busy_q, tx_busy_d;
    logic                  tx_done_q, tx_done_d;

    logic                  unit_tick_s;
    logic [UNIT_W-1:0]     units_s;
    logic [UNIT_W-1:0]     units_target_s;
    logic                  state_end_s;
    logic                  timer_clear_s;

    ir_unit_timer #(
        .T_CLKS (T_CLKS),
        .UNIT_W (UNIT_W)
    ) u_timer (
        .clock         (clock),
        .reset         (reset),
        .clear         (timer_clear_s),
        .unit_tick     (unit_tick_s),
        .units_elapsed (units_s)
    );

    // Last unit index of the current state; the state ends on that unit's final tick
    always_comb begin
        units_target_s = {UNIT_W{1'b0}};
        case (state_q)
            ST_LEAD_ON:  units_target_s = UNIT_W'(LEADER_ON - 32'd1);
            ST_LEAD_OFF: units_target_s = is_repeat_q ? UNIT_W'(REPEAT_OFF - 32'd1)
                                                      : UNIT_W'(LEADER_OFF - 32'd1);
            ST_BIT_ON:   units_target_s = {UNIT_W{1'b0}};
            ST_BIT_OFF:  units_target_s = shift_q[0] ? UNIT_W'(IR_BIT1_SPACE - 32'd1)
                                                     : UNIT_W'(IR_BIT0_SPACE - 32'd1);
            ST_STOP_ON:  units_target_s = {UNIT_W{1'b0}};
            ST_TRAIL:    units_target_s = UNIT_W'(TRAILER - 32'd1);
            default:     units_target_s = {UNIT_W{1'b0}};
        endcase
    end

    assign state_end_s = unit_tick_s && (units_s == units_target_s);

    // Frame sequencing, carrier phase and registered output values
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        is_repeat_d = is_repeat_q;
        case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    state_d     = ST_LEAD_ON;
                    shift_d     = tx_data;
                    is_repeat_d = 1'b0;
                end else if (tx_repeat) begin
                    state_d     = ST_LEAD_ON;
                    is_repeat_d = 1'b1;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_LEAD_ON: begin
                if (state_end_s) state_d = ST_LEAD_OFF;
                else             state_d = ST_LEAD_ON;
            end
            ST_LEAD_OFF: begin
                if (state_end_s) begin
                    state_d   = is_repeat_q ? ST_STOP_ON : ST_BIT_ON;
                    bit_idx_d = {BIT_W{1'b0}};
                end else begin
                    state_d   = ST_LEAD_OFF;
                end
            end
            ST_BIT_ON: begin
                if (state_end_s) state_d = ST_BIT_OFF;
                else             state_d = ST_BIT_ON;
            end
            ST_BIT_OFF: begin
                if (state_end_s) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == BIT_W'(DATA_WIDTH - 32'd1)) begin
                        state_d = ST_STOP_ON;
                    end else begin
                        state_d   = ST_BIT_ON;
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    state_d = ST_BIT_OFF;
                end
            end
            ST_STOP_ON: begin
                if (state_end_s) state_d = ST_TRAIL;
                else             state_d = ST_STOP_ON;
            end
            ST_TRAIL: begin
                if (state_end_s) state_d = ST_IDLE;
                else             state_d = ST_TRAIL;
            end
            default: state_d = ST_IDLE;
        endcase

        timer_clear_s = (state_d != state_q) || (state_q == ST_IDLE);

        // The carrier phase restarts on entry to every mark so each mark begins high
        if (!is_mark(state_d) || (state_d != state_q)) begin
            phase_d = {PH_W{1'b0}};
        end else if (phase_q == PH_W'(CARRIER_DIV - 32'd1)) begin
            phase_d = {PH_W{1'b0}};
        end else begin
            phase_d = phase_q + 1'b1;
        end

        tx_port_d = is_mark(state_d) && (!MODULATE || (phase_d < PH_W'(CARRIER_DIV / 32'd2)));
        tx_busy_d = (state_d != ST_IDLE);
        tx_done_d = (state_q == ST_TRAIL) && state_end_s;
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shift_q     <= {DATA_WIDTH{1'b0}};
            bit_idx_q   <= {BIT_W{1'b0}};
            is_repeat_q <= 1'b0;
            phase_q     <= {PH_W{1'b0}};
            tx_port_q   <= 1'b0;
            tx_busy_q   <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            is_repeat_q <= is_repeat_d;
            phase_q     <= phase_d;
            tx_port_q   <= tx_port_d;
            tx_busy_q   <= tx_busy_d;
            tx_done_q   <= tx_done_d;
        end
    end

    assign tx_port = tx_port_q;
    assign tx_busy = tx_busy_q;
    assign tx_done = tx_done_q;

endmodule
